fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle RISC-V core. Owns the program counter, drives the word address into the instruction memory, and captures the returned instruction plus its PC into an output register handed to decode over a valid/ready handshake. Supports redirects (branch/jump targets) with flush, back-pressure stalls, and a halt-on-fault state for misaligned or out-of-range fetches.

---
 rtl/fetch_unit_if.sv | 67 ++++++
 rtl/fetch_unit.sv | 194 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//
// Bundles the instruction-fetch stage's bus signals:
//   - instruction memory port  (imem_addr out, imem_rdata back)
//   - redirect request         (redirect_valid, redirect_pc)
//   - decode handshake         (out_valid/out_ready plus payload)
//   - status                   (fault, fault_pc, fetch_count)
//
// The master modport is the fetch unit. The slave modport is its environment:
// instruction memory, branch resolution and decode.
// clk and rst are not part of the bundle. They are plain ports on the
// modules that use it.
// -----------------------------------------------------------------------------
interface fetch_unit_if;

  // Instruction memory port
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;

  // Redirect request from branch/jump resolution
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Output register towards decode
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  // Status
  logic [1:0]  fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output fault,
    output fault_pc,
    output fetch_count
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  fault,
    input  fault_pc,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage.
//   - Owns the program counter and presents it as the instruction memory
//     address with zero latency.
//   - Captures the combinationally returned word, together with its PC, into
//     an output register. That register is handed to decode over a
//     valid/ready handshake.
//   - Handles redirects, which load a new PC and flush the output register.
//   - Stalls under back-pressure.
//   - Stops in HALT on a misaligned redirect or an out-of-range fetch.
//     Only rst leaves HALT.
//
// Parameters
//   RESET_PC    PC loaded on reset (word aligned)
//   IMEM_WORDS  instruction memory depth in 32-bit words
//
// Ports
//   clk              core clock, rising edge
//   rst              synchronous, active-high reset
//   bus.imem_addr    byte address to instruction memory (= pc)
//   bus.imem_rdata   instruction word for imem_addr
//   bus.redirect_*   redirect request and target
//   bus.out_*        output register and handshake towards decode
//   bus.fault        sticky fault code (00 none, 01 misaligned, 10 range)
//   bus.fault_pc     offending address captured with the fault
//   bus.fetch_count  instructions loaded into the output register
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_t;

  // The limit is held in 33 bits so that a memory of the full 4 GiB cannot
  // wrap to zero. The comparison is made on the unsigned 32-bit pc.
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) << 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q,        state_d;
  logic [31:0] pc_q,           pc_d;
  logic        out_valid_q,    out_valid_d;
  logic [31:0] out_instr_q,    out_instr_d;
  logic [31:0] out_pc_q,       out_pc_d;
  logic [31:0] out_pc_plus4_q, out_pc_plus4_d;
  fault_t      fault_q,        fault_d;
  logic [31:0] fault_pc_q,     fault_pc_d;
  logic [31:0] fetch_count_q,  fetch_count_d;

  // ---------------------------------------------------------------------------
  // Helper terms
  // ---------------------------------------------------------------------------
  logic        load_cond;
  logic        pc_out_of_range;
  logic        redirect_misaligned;
  logic [31:0] pc_plus4;

  // The output register may be refilled when it is empty, or when decode
  // takes its current content on this edge. This is independent of the fetch
  // address, so out_valid never depends combinationally on out_ready.
  assign load_cond           = !out_valid_q || bus.out_ready;
  assign pc_out_of_range     = {1'b0, pc_q} >= IMEM_LIMIT;
  assign redirect_misaligned = bus.redirect_pc[1:0] != 2'b00;
  assign pc_plus4            = pc_q + 32'd4;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here is given its hold value first, so each
    // path through the case assigns it and no latch is inferred.
    state_d        = state_q;
    pc_d           = pc_q;
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    out_pc_plus4_d = out_pc_plus4_q;
    fault_d        = fault_q;
    fault_pc_d     = fault_pc_q;
    fetch_count_d  = fetch_count_q;

    unique case (state_q)
      // One bubble after reset. Redirects are not looked at here.
      S_IDLE: begin
        out_valid_d = 1'b0;
        state_d     = S_RUN;
      end

      S_RUN: begin
        if (bus.redirect_valid) begin
          // A redirect always flushes the output register. A transfer that
          // decode would have taken on this edge is dropped.
          out_valid_d = 1'b0;
          if (redirect_misaligned) begin
            state_d    = S_HALT;
            fault_d    = FAULT_MISALIGN;
            fault_pc_d = bus.redirect_pc;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else if (load_cond) begin
          if (pc_out_of_range) begin
            state_d     = S_HALT;
            fault_d     = FAULT_RANGE;
            fault_pc_d  = pc_q;
            out_valid_d = 1'b0;
          end else begin
            out_instr_d    = bus.imem_rdata;
            out_pc_d       = pc_q;
            out_pc_plus4_d = pc_plus4;
            out_valid_d    = 1'b1;
            pc_d           = pc_plus4;
            fetch_count_d  = fetch_count_q + 32'd1;
          end
        end
        // Otherwise decode is stalling: everything holds, so imem_addr and
        // the presented instruction stay stable.
      end

      S_HALT: begin
        // Frozen until reset. The output payload keeps its last value.
        out_valid_d = 1'b0;
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: rst is tested inside the clocked block, so the reset is
  // synchronous. It takes effect only at a rising edge and overrides every
  // other input on that edge.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the statement order.
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      out_valid_q    <= 1'b0;
      out_instr_q    <= 32'd0;
      out_pc_q       <= 32'd0;
      out_pc_plus4_q <= 32'd0;
      fault_q        <= FAULT_NONE;
      fault_pc_q     <= 32'd0;
      fetch_count_q  <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      out_pc_plus4_q <= out_pc_plus4_d;
      fault_q        <= fault_d;
      fault_pc_q     <= fault_pc_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.imem_addr    = pc_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_pc_plus4 = out_pc_plus4_q;
  assign bus.fault        = fault_q;
  assign bus.fault_pc     = fault_pc_q;
  assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit through these cases:
//   - reset values
//   - sequential fetch
//   - stall under back-pressure
//   - redirect
//   - halt on an out-of-range fetch
//   - halt on a misaligned redirect
//   - redirect while IDLE
//   - reset during a stall
// It then runs randomized episodes.
//
// Reference model: the stream of instructions decode should accept. After a
// reset, or after an aligned redirect to T, decode must see the words from
// the start address (RESET_PC or T) in ascending order, up to the end of
// memory. When that stream is exhausted the unit halts with a range fault at
// the end of memory. A misaligned redirect ends the stream with a misaligned
// fault at the target address.
// The stimulus side pushes the expected stream into a queue. A monitor pops
// one entry per accepted transfer and compares it.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          WORDS  = 16;
  localparam logic [31:0] END_PC = 32'(WORDS * 4);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Combinational instruction memory. Reads past the end return a marker.
  logic [31:0] mem [WORDS];
  assign bus.imem_rdata = (bus.imem_addr < END_PC) ? mem[bus.imem_addr[5:2]]
                                                   : 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected accepted stream, from 'start' up to the end of memory.
  function automatic void sb_restart(input logic [31:0] start);
    sb_q.delete();
    for (int a = int'(start); a < WORDS * 4; a += 4)
      sb_q.push_back('{pc: 32'(a), instr: mem[a / 4], pc4: 32'(a + 4)});
  endfunction

  // Monitor. Inputs change only just after a rising edge, so the values seen
  // on the falling edge are the ones the next rising edge samples. A transfer
  // flushed by a redirect is not a delivery.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (sb_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL sb_unexpected: got transfer of pc %h expected none",
                 bus.out_pc);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_pc",    bus.out_pc,       mon_e.pc);
        check("sb_instr", bus.out_instr,    mon_e.instr);
        check("sb_pc4",   bus.out_pc_plus4, mon_e.pc4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One reset edge, after which the expected stream restarts from RESET_PC.
  task automatic apply_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    tick();
    sb_restart(32'h0);
    rst = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid),   32'd0);
    check({tag, "_instr"}, bus.out_instr,        32'd0);
    check({tag, "_pc"},    bus.out_pc,           32'd0);
    check({tag, "_pc4"},   bus.out_pc_plus4,     32'd0);
    check({tag, "_fault"}, 32'(bus.fault),       32'd0);
    check({tag, "_fpc"},   bus.fault_pc,         32'd0);
    check({tag, "_count"}, bus.fetch_count,      32'd0);
    check({tag, "_addr"},  bus.imem_addr,        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    logic [1:0]  exp_fault;
    logic [31:0] exp_fpc;
    int          since;

    mem[0] = 32'h0030_0093;
    mem[1] = 32'h0050_0113;
    mem[2] = 32'h0070_0193;
    mem[3] = 32'h0020_81B3;
    for (int i = 4; i < WORDS; i++) mem[i] = $urandom;

    rst = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // ---------------- Sequential fetch, stall, redirect, range halt --------
    apply_reset();
    check_reset_values("rst");
    tick();                                       // edge 1: IDLE -> RUN
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    tick();                                       // edge 2: load word 0
    check("seq0_valid", 32'(bus.out_valid), 32'd1);
    check("seq0_pc",    bus.out_pc,    32'h0);
    check("seq0_instr", bus.out_instr, 32'h0030_0093);
    tick();
    check("seq1_pc",    bus.out_pc,      32'h4);
    check("seq1_count", bus.fetch_count, 32'd2);

    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    bus.out_pc,           32'h4);
      check("stall_instr", bus.out_instr,        32'h0050_0113);
      check("stall_addr",  bus.imem_addr,        32'h8);
      check("stall_count", bus.fetch_count,      32'd2);
      check("stall_valid", 32'(bus.out_valid),   32'd1);
    end
    bus.out_ready = 1'b1;
    tick();
    check("unstall_pc",    bus.out_pc,      32'h8);
    check("unstall_count", bus.fetch_count, 32'd3);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h10;
    sb_restart(32'h10);
    tick();
    bus.redirect_valid = 1'b0;
    check("redir_bubble", 32'(bus.out_valid), 32'd0);
    check("redir_addr",   bus.imem_addr,      32'h10);
    tick();
    check("redir_valid", 32'(bus.out_valid), 32'd1);
    check("redir_pc",    bus.out_pc,         32'h10);
    check("redir_pc4",   bus.out_pc_plus4,   32'h14);
    check("redir_count", bus.fetch_count,    32'd4);

    for (int i = 0; i < 40 && bus.fault == 2'b00; i++) tick();
    check("range_fault", 32'(bus.fault),     32'd2);
    check("range_fpc",   bus.fault_pc,       END_PC);
    check("range_count", bus.fetch_count,    32'd15);
    check("range_valid", 32'(bus.out_valid), 32'd0);
    check("range_drain", 32'(sb_q.size()),   32'd0);

    // HALT ignores everything except reset.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    for (int i = 0; i < 10; i++) tick();
    bus.redirect_valid = 1'b0;
    check("halt_fault", 32'(bus.fault),     32'd2);
    check("halt_addr",  bus.imem_addr,      END_PC);
    check("halt_count", bus.fetch_count,    32'd15);
    check("halt_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- Misaligned redirect ----------------------------------
    apply_reset();
    tick();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h6;
    sb_q.delete();
    tick();
    bus.redirect_valid = 1'b0;
    check("mis_fault", 32'(bus.fault),  32'd1);
    check("mis_fpc",   bus.fault_pc,    32'h6);
    check("mis_addr",  bus.imem_addr,   32'h4);
    for (int i = 0; i < 10; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      check("mis_hold_valid", 32'(bus.out_valid), 32'd0);
      check("mis_hold_fault", 32'(bus.fault),     32'd1);
    end
    check("mis_count", bus.fetch_count, 32'd1);

    // ---------------- Redirect in IDLE, reset mid-stall --------------------
    apply_reset();
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h20;
    tick();                                       // IDLE: redirect ignored
    bus.redirect_valid = 1'b0;
    tick();
    check("idle_redir_valid", 32'(bus.out_valid), 32'd1);
    check("idle_redir_pc",    bus.out_pc,         32'h0);
    check("idle_redir_addr",  bus.imem_addr,      32'h4);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("rst_stall");
    sb_restart(32'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("rel1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("rel2_valid", 32'(bus.out_valid), 32'd1);
    check("rel2_pc",    bus.out_pc,         32'h0);

    // ---------------- Randomized episodes ----------------------------------
    for (int ep = 0; ep < 8; ep++) begin
      apply_reset();
      exp_fault = 2'b00;
      exp_fpc   = 32'h0;
      since     = 0;
      for (int cyc = 0; cyc < 80; cyc++) begin
        bus.out_ready      = ($urandom_range(0, 9) < 7);
        bus.redirect_valid = 1'b0;
        // Redirects only on edges the unit acts on: not the IDLE edge, and
        // not after a halt.
        if (since >= 1 && exp_fault == 2'b00 && sb_q.size() != 0 &&
            $urandom_range(0, 9) == 0) begin
          t = 32'($urandom_range(0, WORDS - 1)) << 2;
          if ($urandom_range(0, 7) == 0) begin
            t = t | 32'($urandom_range(1, 3));
            exp_fault = 2'b01;
            exp_fpc   = t;
            sb_q.delete();
          end else begin
            sb_restart(t);
          end
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = t;
        end
        tick();
        since++;
        if (exp_fault == 2'b00 && sb_q.size() == 0) begin
          exp_fault = 2'b10;
          exp_fpc   = END_PC;
        end
      end
      bus.redirect_valid = 1'b0;
      check("ep_fault", 32'(bus.fault), 32'(exp_fault));
      check("ep_fpc",   bus.fault_pc,   exp_fpc);
      if (exp_fault != 2'b00)
        check("ep_halt_valid", 32'(bus.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
